sd_init_sequencer: RTL and testbench
====================================

# sd_init_sequencer

Sequences the SD-card SPI-mode initialization command flow on top of the byte-level SPI shift engine. It issues CMD0 → CMD8 → (CMD55+ACMD41 loop) → CMD58. It frames each 6-byte command, polls for the R1 response, collects the R3/R7 tail bytes and checks them. On completion it reports ready, the card capacity class, or a coded error to the FAT32 side. It owns chip select and the slow/fast SCLK selection.

## Interface
Parameters:
- NCR_MAX, 8: max 0xFF poll bytes sent while waiting for an R1 (bit7==0).
- ACMD41_RETRIES, 1000: max CMD55+ACMD41 iterations before timeout.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle pulse; begins the sequence. Honoured only in IDLE.
- xfer_start_o  out  1  one-cycle pulse; engine shifts out xfer_byte_o.
- xfer_byte_o  out  8  byte to transmit; held stable from the start pulse until done.
- xfer_done_i  in  1  one-cycle pulse; the transfer is complete and xfer_byte_i is valid.
- xfer_byte_i  in  8  byte received on MISO during that transfer.
- cs_n_o  out  1  card chip select, active low.
- speed_fast_o  out  1  0 = 400 kHz divider, 1 = 25 MHz divider.
- busy_o  out  1  sequence in progress.
- init_done_o  out  1  card initialized; sticky until rst.
- ccs_o  out  1  OCR bit 30 (high capacity), valid when init_done_o=1.
- init_err_o  out  1  sequence failed; sticky until rst or the next start_i.
- err_code_o  out  3  failure cause: 0 none, 1 CMD0 R1≠0x01, 2 CMD8 bad R1/echo, 3 ACMD41 timeout, 4 NCR timeout, 5 CMD58 R1≠0x00.

## Operation
- States: IDLE, SEND (byte index 0..5), POLL, TAIL (byte index 0..3), SPACER, EVAL, DONE, ERROR.
- Command register cmd_sel ∈ {CMD0, CMD8, CMD55, CMD41, CMD58}.
- Frame bytes, in order:
  - 0x40|idx
  - arg[31:24], arg[23:16], arg[15:8], arg[7:0]
  - CRC: CMD0 0x95, CMD8 0x87, all others 0x01
- Arguments: CMD0 0, CMD8 0x000001AA, CMD55 0, CMD41 0x40000000, CMD58 0.
- IDLE + start_i:
  - cs_n_o←0, busy_o←1.
  - Clear init_err_o and err_code_o, reset the retry counter.
  - cmd_sel←CMD0, go to SEND.
- SEND: transmit the 6 frame bytes, then POLL with the poll counter cleared.
- POLL: transmit 0xFF.
  - Received bit7==0: latch R1. CMD8/CMD58 go to TAIL; all others go to SPACER.
  - Otherwise increment the poll counter. On reaching NCR_MAX: err 4 → ERROR.
- TAIL: transmit 4×0xFF and shift the received bytes into tail[31:0], MSB first; then SPACER.
- SPACER: cs_n_o←1, transmit one 0xFF, then EVAL.
- EVAL (one cycle, no transfer):
  - CMD0: R1==0x01 → CMD8; else err 1.
  - CMD8: R1==0x01 and tail[11:0]==0x1AA → CMD55; else err 2.
  - CMD55: R1∈{0x00,0x01} → CMD41; else err 3.
  - CMD41:
    - R1==0x00 → CMD58.
    - R1==0x01: increment retries; if retries==ACMD41_RETRIES, err 3; else CMD55.
    - Any other R1: err 3.
  - CMD58: R1==0x00 → ccs_o←tail[30], DONE; else err 5.
  - Any next command re-asserts cs_n_o←0 on entering SEND.
- DONE: init_done_o←1, speed_fast_o←1, busy_o←0, stay until rst.
- ERROR: init_err_o←1, busy_o←0, cs_n_o←1, speed_fast_o←0, return to IDLE. Restartable via start_i.
- Counters:
  - Poll counter is clog2(NCR_MAX+1) bits.
  - Retry counter is clog2(ACMD41_RETRIES+1) bits.
  - Neither wraps; both saturate at their limit.

## Timing
- Reset values: xfer_start_o 0, xfer_byte_o 0xFF, cs_n_o 1, speed_fast_o 0, busy_o 0, init_done_o 0, ccs_o 0, init_err_o 0, err_code_o 0; state IDLE.
- start_i → first xfer_start_o: 1 cycle.
- At most one transfer outstanding. The next xfer_start_o comes no earlier than the cycle after xfer_done_i.
- xfer_done_i with no outstanding transfer is ignored.
- start_i outside IDLE is ignored, including in DONE.
- rst mid-transfer: immediate return to reset values. A late xfer_done_i is ignored.
- cs_n_o changes only in cycles with no outstanding transfer.
- EVAL → ERROR/DONE outputs become visible 1 cycle after EVAL.

## Test plan
- Happy path. Card model answers:
  - CMD0 with 0x01.
  - CMD8 with 0x01 followed by 00 00 01 AA.
  - CMD41 with 0x01 twice, then 0x00.
  - CMD58 with 0x00 followed by C0 FF 80 00.
  - Required: init_done_o=1, ccs_o=1, speed_fast_o=1, err_code_o=0. Byte log shows 3 CMD55/CMD41 pairs and first frame 40 00 00 00 00 95.
- CMD0 poll always 0xFF → exactly 6+NCR_MAX=14 transfers, then init_err_o=1, err_code_o=4, cs_n_o=1.
- CMD8 echo 00 00 01 AB → err_code_o=2; no CMD55 frame is ever sent.
- ACMD41_RETRIES=3, CMD41 always 0x01 → exactly 3 CMD41 frames, then err_code_o=3.
- start_i pulsed mid-CMD8 is ignored. rst asserted mid-CMD8 transfer → all outputs at reset values next cycle. A subsequent start_i re-runs from CMD0.
- Re-start after an error clears init_err_o and err_code_o on start_i and completes normally.

Source files
------------

// File: rtl/sd_init_sequencer.sv
// rtl/sd_init_sequencer.sv - SD SPI-mode init sequencer: CMD0, CMD8, CMD55/ACMD41 loop, CMD58
module sd_init_sequencer #(
  parameter int NCR_MAX        = 8,
  parameter int ACMD41_RETRIES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  output logic       xfer_start_o,
  output logic [7:0] xfer_byte_o,
  input  logic       xfer_done_i,
  input  logic [7:0] xfer_byte_i,
  output logic       cs_n_o,
  output logic       speed_fast_o,
  output logic       busy_o,
  output logic       init_done_o,
  output logic       ccs_o,
  output logic       init_err_o,
  output logic [2:0] err_code_o
);

  localparam int PW = $clog2(NCR_MAX + 1);
  localparam int RW = $clog2(ACMD41_RETRIES + 1);
  localparam logic [PW-1:0] POLL_LIM  = PW'(NCR_MAX);
  localparam logic [RW-1:0] RETRY_LIM = RW'(ACMD41_RETRIES);

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_CMD0  = 3'd1;
  localparam logic [2:0] ERR_CMD8  = 3'd2;
  localparam logic [2:0] ERR_ACMD  = 3'd3;
  localparam logic [2:0] ERR_NCR   = 3'd4;
  localparam logic [2:0] ERR_CMD58 = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_POLL, S_TAIL, S_SPACER, S_EVAL, S_DONE, S_ERROR
  } state_t;

  typedef enum logic [2:0] {
    C_CMD0, C_CMD8, C_CMD55, C_CMD41, C_CMD58
  } cmd_t;

  state_t        state_q, state_d;
  cmd_t          cmd_q, cmd_d;
  logic [2:0]    idx_q, idx_d;
  logic [PW-1:0] poll_q, poll_d, poll_inc;
  logic [RW-1:0] retry_q, retry_d, retry_inc;
  logic [7:0]    r1_q, r1_d;
  // Only the OCR CCS bit and the CMD8 check-pattern echo of the 32-bit
  // tail are ever consulted, so just those fields are captured.
  logic          ccs_cand_q, ccs_cand_d;
  logic [11:0]   echo_q, echo_d;
  logic          pend_q, pend_d;
  logic          cs_n_q, cs_n_d;
  logic          fast_q, fast_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ccs_q, ccs_d;
  logic          err_q, err_d;
  logic [2:0]    code_q, code_d;

  logic [5:0]    cmd_index;
  logic [31:0]   cmd_arg;
  logic [7:0]    cmd_crc;
  logic [7:0]    tx_byte;
  logic          xfer_state;
  logic          issue;
  logic          xfer_ok;
  logic          fail;
  logic [2:0]    fail_code;
  logic          launch;

  // Frame content of the selected command and the byte currently presented to the engine.
  always_comb begin
    cmd_index = 6'd0;
    cmd_arg   = 32'h0000_0000;
    cmd_crc   = 8'h01;
    case (cmd_q)
      C_CMD0:  begin cmd_index = 6'd0;  cmd_crc = 8'h95; end
      C_CMD8:  begin cmd_index = 6'd8;  cmd_arg = 32'h0000_01AA; cmd_crc = 8'h87; end
      C_CMD55: cmd_index = 6'd55;
      C_CMD41: begin cmd_index = 6'd41; cmd_arg = 32'h4000_0000; end
      C_CMD58: cmd_index = 6'd58;
      default: cmd_index = 6'd0;
    endcase
    tx_byte = 8'hFF;
    if (state_q == S_SEND) begin
      case (idx_q)
        3'd0:    tx_byte = {2'b01, cmd_index};
        3'd1:    tx_byte = cmd_arg[31:24];
        3'd2:    tx_byte = cmd_arg[23:16];
        3'd3:    tx_byte = cmd_arg[15:8];
        3'd4:    tx_byte = cmd_arg[7:0];
        3'd5:    tx_byte = cmd_crc;
        default: tx_byte = 8'hFF;
      endcase
    end
  end

  // A transfer is launched whenever a byte-moving state has nothing outstanding;
  // the state and index hold still until the matching done, keeping the byte stable.
  always_comb begin
    xfer_state = (state_q == S_SEND) || (state_q == S_POLL) ||
                 (state_q == S_TAIL) || (state_q == S_SPACER);
    issue      = xfer_state && !pend_q;
    xfer_ok    = pend_q && xfer_done_i;
  end

  // Next-state logic: command sequencing, response capture and result evaluation.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    idx_d      = idx_q;
    poll_d     = poll_q;
    retry_d    = retry_q;
    r1_d       = r1_q;
    ccs_cand_d = ccs_cand_q;
    echo_d     = echo_q;
    pend_d     = pend_q;
    cs_n_d     = cs_n_q;
    fast_d     = fast_q;
    busy_d     = busy_q;
    done_d     = done_q;
    ccs_d      = ccs_q;
    err_d      = err_q;
    code_d     = code_q;
    fail       = 1'b0;
    fail_code  = ERR_NONE;
    launch     = 1'b0;
    poll_inc   = (poll_q == POLL_LIM) ? poll_q : poll_q + 1'b1;
    retry_inc  = (retry_q == RETRY_LIM) ? retry_q : retry_q + 1'b1;

    if (issue) begin
      pend_d = 1'b1;
    end else if (xfer_ok) begin
      pend_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          code_d  = ERR_NONE;
          retry_d = '0;
          cmd_d   = C_CMD0;
          idx_d   = 3'd0;
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        if (xfer_ok) begin
          if (idx_q == 3'd5) begin
            poll_d  = '0;
            state_d = S_POLL;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      S_POLL: begin
        if (xfer_ok) begin
          if (!xfer_byte_i[7]) begin
            r1_d = xfer_byte_i;
            if (cmd_q == C_CMD8 || cmd_q == C_CMD58) begin
              idx_d   = 3'd0;
              state_d = S_TAIL;
            end else begin
              cs_n_d  = 1'b1;
              state_d = S_SPACER;
            end
          end else begin
            poll_d = poll_inc;
            if (poll_inc == POLL_LIM) begin
              fail      = 1'b1;
              fail_code = ERR_NCR;
            end
          end
        end
      end

      S_TAIL: begin
        if (xfer_ok) begin
          case (idx_q)
            3'd0:    ccs_cand_d   = xfer_byte_i[6];
            3'd2:    echo_d[11:8] = xfer_byte_i[3:0];
            3'd3:    echo_d[7:0]  = xfer_byte_i;
            default: ;
          endcase
          if (idx_q == 3'd3) begin
            cs_n_d  = 1'b1;
            state_d = S_SPACER;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      S_SPACER: begin
        if (xfer_ok) begin
          state_d = S_EVAL;
        end
      end

      S_EVAL: begin
        case (cmd_q)
          C_CMD0: begin
            if (r1_q == 8'h01) begin
              cmd_d  = C_CMD8;
              launch = 1'b1;
            end else begin
              fail      = 1'b1;
              fail_code = ERR_CMD0;
            end
          end
          C_CMD8: begin
            if (r1_q == 8'h01 && echo_q == 12'h1AA) begin
              cmd_d  = C_CMD55;
              launch = 1'b1;
            end else begin
              fail      = 1'b1;
              fail_code = ERR_CMD8;
            end
          end
          C_CMD55: begin
            if (r1_q == 8'h00 || r1_q == 8'h01) begin
              cmd_d  = C_CMD41;
              launch = 1'b1;
            end else begin
              fail      = 1'b1;
              fail_code = ERR_ACMD;
            end
          end
          C_CMD41: begin
            if (r1_q == 8'h00) begin
              cmd_d  = C_CMD58;
              launch = 1'b1;
            end else if (r1_q == 8'h01) begin
              retry_d = retry_inc;
              if (retry_inc == RETRY_LIM) begin
                fail      = 1'b1;
                fail_code = ERR_ACMD;
              end else begin
                cmd_d  = C_CMD55;
                launch = 1'b1;
              end
            end else begin
              fail      = 1'b1;
              fail_code = ERR_ACMD;
            end
          end
          C_CMD58: begin
            if (r1_q == 8'h00) begin
              ccs_d   = ccs_cand_q;
              done_d  = 1'b1;
              fast_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_DONE;
            end else begin
              fail      = 1'b1;
              fail_code = ERR_CMD58;
            end
          end
          default: begin
            fail      = 1'b1;
            fail_code = ERR_ACMD;
          end
        endcase
        if (launch) begin
          idx_d   = 3'd0;
          cs_n_d  = 1'b0;
          state_d = S_SEND;
        end
      end

      S_DONE: begin
        state_d = S_DONE;
      end

      S_ERROR: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Every failure path funnels here so ERROR is entered with a consistent output set.
    if (fail) begin
      state_d = S_ERROR;
      err_d   = 1'b1;
      code_d  = fail_code;
      busy_d  = 1'b0;
      cs_n_d  = 1'b1;
      fast_d  = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cmd_q      <= C_CMD0;
      idx_q      <= 3'd0;
      poll_q     <= '0;
      retry_q    <= '0;
      r1_q       <= 8'hFF;
      ccs_cand_q <= 1'b0;
      echo_q     <= 12'h000;
      pend_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      fast_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ccs_q      <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      idx_q      <= idx_d;
      poll_q     <= poll_d;
      retry_q    <= retry_d;
      r1_q       <= r1_d;
      ccs_cand_q <= ccs_cand_d;
      echo_q     <= echo_d;
      pend_q     <= pend_d;
      cs_n_q     <= cs_n_d;
      fast_q     <= fast_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ccs_q      <= ccs_d;
      err_q      <= err_d;
      code_q     <= code_d;
    end
  end

  assign xfer_start_o = issue;
  assign xfer_byte_o  = tx_byte;
  assign cs_n_o       = cs_n_q;
  assign speed_fast_o = fast_q;
  assign busy_o       = busy_q;
  assign init_done_o  = done_q;
  assign ccs_o        = ccs_q;
  assign init_err_o   = err_q;
  assign err_code_o   = code_q;

endmodule

// File: tb/tb_sd_init_sequencer.sv
// tb/tb_sd_init_sequencer.sv - randomized bench for sd_init_sequencer against a card and sequence model
module tb_sd_init_sequencer;

  localparam int NCR     = 8;
  localparam int RETRIES = 3;
  localparam logic [17:0] RST_VEC = {1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0;
  logic       xfer_start_o;
  logic [7:0] xfer_byte_o;
  logic       xfer_done_i = 1'b0;
  logic [7:0] xfer_byte_i = 8'hFF;
  logic       cs_n_o, speed_fast_o, busy_o, init_done_o, ccs_o, init_err_o;
  logic [2:0] err_code_o;

  always #5 clk = ~clk;

  sd_init_sequencer #(.NCR_MAX(NCR), .ACMD41_RETRIES(RETRIES)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .xfer_start_o (xfer_start_o),
    .xfer_byte_o  (xfer_byte_o),
    .xfer_done_i  (xfer_done_i),
    .xfer_byte_i  (xfer_byte_i),
    .cs_n_o       (cs_n_o),
    .speed_fast_o (speed_fast_o),
    .busy_o       (busy_o),
    .init_done_o  (init_done_o),
    .ccs_o        (ccs_o),
    .init_err_o   (init_err_o),
    .err_code_o   (err_code_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // card behaviour for the current scenario
  logic        c_silent;
  logic [7:0]  c_r1_0, c_r1_8, c_r1_55, c_r1_41, c_r1_58;
  logic [31:0] c_echo, c_ocr;
  int          c_busy;

  logic        in_frame = 1'b0;
  logic [7:0]  frame[$];
  logic [7:0]  resp_q[$];
  int          seen_cmds[$];
  int          n41 = 0;

  int          exp_cmds[$];
  int          exp_code;
  logic        exp_done, exp_ccs;

  logic        eng_busy = 1'b0, eng_stale = 1'b0, eng_cs = 1'b1;
  logic [7:0]  eng_tx = 8'hFF, eng_resp = 8'hFF;
  int          eng_wait = 0;
  int          xfer_count = 0;
  int          viol = 0;

  function automatic logic [47:0] exp_frame(input int cmd);
    case (cmd)
      0:       return {8'h40, 32'h0000_0000, 8'h95};
      8:       return {8'h48, 32'h0000_01AA, 8'h87};
      55:      return {8'h77, 32'h0000_0000, 8'h01};
      41:      return {8'h69, 32'h4000_0000, 8'h01};
      58:      return {8'h7A, 32'h0000_0000, 8'h01};
      default: return 48'h0;
    endcase
  endfunction

  function automatic int count_cmd(input int cmd);
    int n = 0;
    foreach (seen_cmds[i]) if (seen_cmds[i] == cmd) n++;
    return n;
  endfunction

  function automatic logic [17:0] out_vec();
    return {xfer_start_o, xfer_byte_o, cs_n_o, speed_fast_o, busy_o,
            init_done_o, ccs_o, init_err_o, err_code_o};
  endfunction

  task automatic card_respond();
    logic [7:0]  b0, r1;
    logic [31:0] tail;
    logic        has_tail;
    int          cmd, lat;
    b0 = frame[0];
    cmd = int'(b0[5:0]);
    check("frame", {frame[0], frame[1], frame[2], frame[3], frame[4], frame[5]}, exp_frame(cmd));
    seen_cmds.push_back(cmd);
    if (cmd == 0 && c_silent) return;
    has_tail = 1'b0;
    tail = 32'h0;
    case (cmd)
      0:  r1 = c_r1_0;
      8:  begin r1 = c_r1_8; tail = c_echo; has_tail = 1'b1; end
      55: r1 = c_r1_55;
      41: begin r1 = (n41 < c_busy) ? 8'h01 : c_r1_41; n41++; end
      58: begin r1 = c_r1_58; tail = c_ocr; has_tail = 1'b1; end
      default: r1 = 8'h04;
    endcase
    lat = $urandom_range(0, NCR - 1);
    repeat (lat) resp_q.push_back(8'hFF);
    resp_q.push_back(r1);
    if (has_tail) for (int i = 3; i >= 0; i--) resp_q.push_back(tail[8*i +: 8]);
  endtask

  task automatic card_byte(input logic [7:0] tx, input logic cs, output logic [7:0] rx);
    rx = 8'hFF;
    if (cs) return;
    if (in_frame) begin
      frame.push_back(tx);
      if (frame.size() == 6) begin
        in_frame = 1'b0;
        card_respond();
      end
    end else if (tx[7:6] == 2'b01) begin
      frame.delete();
      frame.push_back(tx);
      in_frame = 1'b1;
    end else if (resp_q.size() > 0) begin
      rx = resp_q.pop_front();
    end
  endtask

  // SPI engine stand-in: accepts one transfer, answers after a random delay
  initial begin
    forever begin
      @(negedge clk);
      xfer_done_i = 1'b0;
      if (rst) eng_stale = 1'b1;
      if (eng_busy) begin
        if (!eng_stale && (xfer_start_o || xfer_byte_o != eng_tx || cs_n_o != eng_cs)) viol++;
        eng_wait--;
        if (eng_wait == 0) begin
          xfer_done_i = 1'b1;
          xfer_byte_i = eng_resp;
          eng_busy    = 1'b0;
        end
      end else if (xfer_start_o && !rst) begin
        eng_tx    = xfer_byte_o;
        eng_cs    = cs_n_o;
        eng_stale = 1'b0;
        card_byte(xfer_byte_o, cs_n_o, eng_resp);
        eng_wait  = $urandom_range(1, 3);
        eng_busy  = 1'b1;
        xfer_count++;
      end
    end
  end

  // spec-level expectation of the command sequence and outcome
  task automatic predict();
    int k;
    logic [7:0] r;
    exp_cmds.delete();
    exp_code = 0;
    exp_done = 1'b0;
    exp_ccs  = 1'b0;
    exp_cmds.push_back(0);
    if (c_silent) begin exp_code = 4; return; end
    if (c_r1_0 != 8'h01) begin exp_code = 1; return; end
    exp_cmds.push_back(8);
    if (c_r1_8 != 8'h01 || c_echo[11:0] != 12'h1AA) begin exp_code = 2; return; end
    k = 0;
    forever begin
      exp_cmds.push_back(55);
      if (c_r1_55 > 8'h01) begin exp_code = 3; return; end
      exp_cmds.push_back(41);
      r = (k < c_busy) ? 8'h01 : c_r1_41;
      if (r == 8'h00) break;
      if (r != 8'h01) begin exp_code = 3; return; end
      k++;
      if (k == RETRIES) begin exp_code = 3; return; end
    end
    exp_cmds.push_back(58);
    if (c_r1_58 != 8'h00) begin exp_code = 5; return; end
    exp_done = 1'b1;
    exp_ccs  = c_ocr[30];
  endtask

  task automatic set_happy();
    c_silent = 1'b0;
    c_r1_0   = 8'h01;
    c_r1_8   = 8'h01;
    c_echo   = 32'h0000_01AA;
    c_r1_55  = 8'h01;
    c_busy   = 2;
    c_r1_41  = 8'h00;
    c_r1_58  = 8'h00;
    c_ocr    = 32'hC0FF_8000;
  endtask

  task automatic clear_card();
    in_frame = 1'b0;
    frame.delete();
    resp_q.delete();
    seen_cmds.delete();
    n41 = 0;
    viol = 0;
  endtask

  task automatic wait_eng_idle(input string tag);
    int cyc = 0;
    while (eng_busy && cyc < 20) begin @(negedge clk); cyc++; end
    check({tag, ":eng_idle"}, eng_busy, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    wait_eng_idle("reset");
    clear_card();
  endtask

  task automatic run_seq(input string tag);
    int cyc;
    predict();
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    check({tag, ":launch"}, {busy_o, init_err_o, err_code_o, xfer_start_o}, {1'b1, 1'b0, 3'd0, 1'b1});
    cyc = 0;
    while (busy_o && cyc < 5000) begin @(negedge clk); cyc++; end
    check({tag, ":timeout"}, busy_o, 1'b0);
    check({tag, ":done"}, init_done_o, exp_done);
    check({tag, ":err"}, init_err_o, exp_code != 0);
    check({tag, ":code"}, err_code_o, exp_code);
    check({tag, ":ccs"}, ccs_o, exp_ccs);
    check({tag, ":fast"}, speed_fast_o, exp_done);
    check({tag, ":cs_n"}, cs_n_o, 1'b1);
    check({tag, ":ncmd"}, seen_cmds.size(), exp_cmds.size());
    for (int i = 0; i < seen_cmds.size() && i < exp_cmds.size(); i++)
      check({tag, ":cmd"}, seen_cmds[i], exp_cmds[i]);
    check({tag, ":proto"}, viol, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0, cyc;
    logic [31:0] tmp;

    repeat (3) @(negedge clk);
    check("reset_vals", out_vec(), RST_VEC);
    rst = 1'b0;
    clear_card();
    @(negedge clk);
    check("idle_vals", out_vec(), RST_VEC);

    set_happy();
    run_seq("happy");
    check("happy:n55", count_cmd(55), 3);
    check("happy:n41", count_cmd(41), 3);

    x0 = xfer_count;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    repeat (10) @(negedge clk);
    check("done_start:xfers", xfer_count - x0, 0);
    check("done_start:state", {busy_o, init_done_o, speed_fast_o}, 3'b011);

    do_reset();
    set_happy();
    c_silent = 1'b1;
    x0 = xfer_count;
    run_seq("ncr");
    check("ncr:xfers", xfer_count - x0, 6 + NCR);

    clear_card();
    set_happy();
    run_seq("restart");

    do_reset();
    set_happy();
    c_echo = 32'h0000_01AB;
    run_seq("echo");
    check("echo:n55", count_cmd(55), 0);

    do_reset();
    set_happy();
    c_busy = 100;
    run_seq("acmd_to");
    check("acmd_to:n41", count_cmd(41), RETRIES);

    do_reset();
    set_happy();
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    cyc = 0;
    while (!(in_frame && frame.size() > 0 && frame[0] == 8'h48) && cyc < 2000) begin
      @(negedge clk); cyc++;
    end
    check("mid:cmd8_seen", in_frame, 1'b1);
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    cyc = 0;
    while (seen_cmds.size() < 2 && cyc < 2000) begin @(negedge clk); cyc++; end
    check("mid:ncmd", seen_cmds.size(), 2);
    check("mid:busy", busy_o, 1'b1);
    cyc = 0;
    while (!eng_busy && cyc < 20) begin @(negedge clk); cyc++; end
    check("mid:outstanding", eng_busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("mid:rst_vals", out_vec(), RST_VEC);
    @(negedge clk); rst = 1'b0;
    wait_eng_idle("mid");
    repeat (3) @(negedge clk);
    check("mid:after_late_done", out_vec(), RST_VEC);
    clear_card();
    set_happy();
    run_seq("rerun");

    for (int it = 0; it < 16; it++) begin
      do_reset();
      c_silent = ($urandom_range(0, 9) == 0);
      c_r1_0   = ($urandom_range(0, 7) == 0) ? 8'h05 : 8'h01;
      c_r1_8   = ($urandom_range(0, 7) == 0) ? 8'h05 : 8'h01;
      tmp      = $urandom;
      c_echo   = ($urandom_range(0, 7) == 0) ? tmp : {tmp[31:12], 12'h1AA};
      c_r1_55  = ($urandom_range(0, 7) == 0) ? 8'h04 : 8'($urandom_range(0, 1));
      c_busy   = $urandom_range(0, 3);
      c_r1_41  = ($urandom_range(0, 7) == 0) ? 8'h05 : 8'h00;
      c_r1_58  = ($urandom_range(0, 7) == 0) ? 8'h01 : 8'h00;
      c_ocr    = $urandom;
      run_seq("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
